// File: rtl/sqrt_digit_rec.sv
// sqrt_digit_rec: radix-2 digit-recurrence square root, one root bit per cycle.
// Revision 1.0 - initial release.
`default_nettype none

module sqrt_digit_rec (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_exp_odd,
  input  logic [23:0] in_sig,
  output logic        done,
  output logic        busy,
  output logic [43:0] sqrt_sig,
  output logic        sqrt_rem_nz
);

  localparam logic [5:0] LAST_ITER = 6'd43;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [87:0] rad;
  logic [45:0] rem;
  logic [43:0] q;
  logic [5:0]  cnt;

  logic [47:0] t;
  logic [47:0] trial;
  logic        take;
  logic [45:0] rem_sub;
  logic [45:0] rem_nxt;
  logic [43:0] q_nxt;
  logic        last;
  logic [87:0] rad_init;

  // Odd exponents shift one place further so the radicand exponent is even.
  assign rad_init = is_exp_odd ? {in_sig, 64'd0} : {1'b0, in_sig, 63'd0};

  assign t       = {rem, rad[87:86]};
  assign trial   = {2'b00, q, 2'b01};
  assign take    = (t >= trial);
  // The true difference always fits in 46 bits when take is set.
  assign rem_sub = t[45:0] - trial[45:0];
  assign rem_nxt = take ? rem_sub : t[45:0];
  assign q_nxt   = {q[42:0], take};
  assign last    = (cnt == LAST_ITER);

  assign busy = (state == BUSY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rad         <= '0;
      rem         <= '0;
      q           <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      sqrt_sig    <= '0;
      sqrt_rem_nz <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          rad <= rad_init;
          rem <= '0;
          q   <= '0;
          cnt <= '0;
        end
      end else begin
        rem <= rem_nxt;
        q   <= q_nxt;
        rad <= {rad[85:0], 2'b00};
        cnt <= cnt + 6'd1;
        if (last) begin
          sqrt_sig    <= q_nxt;
          sqrt_rem_nz <= |rem_nxt;
          done        <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
